papu_mix_sequencer: RTL and testbench

Sequencer that time-multiplexes one shared multiply-accumulate path across the APU voice channels (pulse 1, pulse 2, triangle, noise) and produces one signed 16-bit mixed sample per codec `sample_req`. It sits between the per-channel generators and the audio-effects/codec output stage, replacing per-channel mixers with a single serial datapath. On each request it polls each unmuted channel with a req/ack handshake, weights the channel level by a per-channel gain, accumulates, re-centres and publishes the result.

---
 rtl/papu_pkg.sv | 32 +++
 rtl/papu_mix_mac.sv | 54 +++++
 rtl/papu_mix_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_papu_mix_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/papu_pkg.sv
// papu_pkg
// Shared types and constants for the APU mix sequencer slice.
//   mix_state_t  : sequencer FSM states
//   LEVEL_W/GAIN_W/ACC_W : datapath widths (4-bit level, 4-bit gain, 10-bit accumulator)
//   MIX_SHIFT/MIX_OFFSET : scaling and re-centring applied to the accumulator on publish
//   mix_recentre : turns an unsigned accumulator into a signed, zero-centred sample
package papu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_WAIT,
    ST_ACC,
    ST_FIN
  } mix_state_t;

  localparam int LEVEL_W   = 4;
  localparam int GAIN_W    = 4;
  localparam int PROD_W    = LEVEL_W + GAIN_W;
  localparam int ACC_W     = 10;
  localparam int MIX_SHIFT = 5;
  localparam logic signed [15:0] MIX_OFFSET = 16'sd14400;

  // Full-scale accumulator (900) lands at +14400 and zero lands at -14400,
  // so the scaled value always fits a signed 16-bit sample.
  function automatic logic signed [15:0] mix_recentre(input logic [ACC_W-1:0] acc);
    logic [15:0] scaled;
    scaled = 16'(acc) << MIX_SHIFT;
    return $signed(scaled) - MIX_OFFSET;
  endfunction

endpackage

// File: rtl/papu_mix_mac.sv
// papu_mix_mac
// Shared multiply-accumulate path for the mix sequencer: one level x gain
// product per enable, a clearable accumulator, and a published output sample.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : zero the accumulator (start of frame)
//   i_en       : add i_level * i_gain to the accumulator
//   i_level    : 4-bit channel level
//   i_gain     : 4-bit channel gain
//   i_pub      : load the re-centred accumulator into o_audio
//   o_audio    : signed 16-bit mixed sample, held between publishes
module papu_mix_mac
  import papu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [LEVEL_W-1:0] i_level,
  input  logic [GAIN_W-1:0]  i_gain,
  input  logic               i_pub,
  output logic [15:0]        o_audio
);

  logic [ACC_W-1:0]  r_acc;
  logic [15:0]       r_audio;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_sum;

  // 15*15 per channel and four channels top out at 900, so 10 bits never wrap.
  assign w_prod = i_level * i_gain;
  assign w_sum  = r_acc + ACC_W'(w_prod);

  // Accumulator and output register. Clear has priority so a new frame
  // always starts from zero regardless of what the enable is doing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_audio <= '0;
    end else begin
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_en) begin
        r_acc <= w_sum;
      end
      if (i_pub) begin
        r_audio <= mix_recentre(r_acc);
      end
    end
  end

  assign o_audio = r_audio;

endmodule

// File: rtl/papu_mix_sequencer.sv
// papu_mix_sequencer
// Time-multiplexes one MAC across the APU voice channels. Each sample_req
// polls every unmuted channel in index order with a req/ack handshake,
// weights its level by the channel gain and publishes one signed sample.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_sample_req     : codec request for a new sample (1-cycle pulse)
//   o_ch_req         : one-hot level request to the channel being polled
//   i_ch_ack         : per-channel "level valid this cycle"
//   i_ch_level       : 4-bit level per channel, slice i = [4i+3:4i]
//   i_gain           : 4-bit gain per channel, static during a frame
//   i_mute           : skip channel, contributes 0
//   i_clr_err        : clear sticky flags (a same-cycle new error wins)
//   o_audio_output   : signed mixed sample, held until next publish
//   o_sample_valid   : 1-cycle pulse when o_audio_output updates
//   o_busy           : high whenever a frame is in progress
//   o_overrun        : sticky, sample_req arrived while busy
//   o_timeout_err    : sticky, a channel failed to ack in TIMEOUT cycles
module papu_mix_sequencer
  import papu_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_sample_req,
  output logic [NUM_CH-1:0]         o_ch_req,
  input  logic [NUM_CH-1:0]         i_ch_ack,
  input  logic [LEVEL_W*NUM_CH-1:0] i_ch_level,
  input  logic [GAIN_W*NUM_CH-1:0]  i_gain,
  input  logic [NUM_CH-1:0]         i_mute,
  input  logic                      i_clr_err,
  output logic [15:0]               o_audio_output,
  output logic                      o_sample_valid,
  output logic                      o_busy,
  output logic                      o_overrun,
  output logic                      o_timeout_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  CNT_LIM  = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_CH-1:0] REQ_CH0  = NUM_CH'(1);

  mix_state_t         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [LEVEL_W-1:0] r_level;
  logic [NUM_CH-1:0]  r_ch_req;
  logic               r_sample_valid;
  logic               r_busy;
  logic               r_overrun;
  logic               r_timeout_err;

  logic               w_ack_sel;
  logic               w_mute_sel;
  logic [LEVEL_W-1:0] w_level_sel;
  logic [GAIN_W-1:0]  w_gain_sel;
  logic               w_last;
  logic               w_tmo_hit;
  logic               w_ovr_evt;
  logic               w_acc_clr;
  logic               w_acc_en;
  logic               w_pub;
  logic [15:0]        w_audio;

  // Pick out the ack, mute, level and gain of the channel currently indexed.
  // Acks from any other channel simply never reach the FSM.
  always_comb begin
    w_ack_sel   = 1'b0;
    w_mute_sel  = 1'b0;
    w_level_sel = '0;
    w_gain_sel  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_ack_sel   = i_ch_ack[i];
        w_mute_sel  = i_mute[i];
        w_level_sel = i_ch_level[i*LEVEL_W +: LEVEL_W];
        w_gain_sel  = i_gain[i*GAIN_W +: GAIN_W];
      end
    end
  end

  assign w_last    = (r_idx == LAST_IDX);
  // The counter starts at 0 on entry to WAIT, so the TIMEOUT-th silent WAIT
  // cycle is the one where it sits at TIMEOUT-1. An ack on that cycle still wins.
  assign w_tmo_hit = (r_state == ST_WAIT) && !w_ack_sel && (r_wait_cnt == CNT_LIM);
  assign w_ovr_evt = i_sample_req && (r_state != ST_IDLE);

  assign w_acc_clr = (r_state == ST_IDLE) && i_sample_req;
  assign w_acc_en  = (r_state == ST_ACC);
  assign w_pub     = (r_state == ST_FIN);

  // Sequencer FSM. All outputs are registered here, so ch_req rises the cycle
  // WAIT is entered and falls the cycle after the ack (or timeout). Sticky
  // flags sit in the same block: a new error event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_wait_cnt     <= '0;
      r_level        <= '0;
      r_ch_req       <= '0;
      r_sample_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;

      if (w_ovr_evt) begin
        r_overrun <= 1'b1;
      end else if (i_clr_err) begin
        r_overrun <= 1'b0;
      end

      if (w_tmo_hit) begin
        r_timeout_err <= 1'b1;
      end else if (i_clr_err) begin
        r_timeout_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_sample_req) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SEL;
          end
        end
        ST_SEL: begin
          if (w_mute_sel) begin
            if (w_last) begin
              r_state <= ST_FIN;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_wait_cnt <= '0;
            r_ch_req   <= REQ_CH0 << r_idx;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_ack_sel) begin
            r_level  <= w_level_sel;
            r_ch_req <= '0;
            r_state  <= ST_ACC;
          end else if (w_tmo_hit) begin
            r_level  <= '0;
            r_ch_req <= '0;
            r_state  <= ST_ACC;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_ACC: begin
          if (w_last) begin
            r_state <= ST_FIN;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ST_SEL;
          end
        end
        ST_FIN: begin
          r_sample_valid <= 1'b1;
          r_busy         <= 1'b0;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_ch_req <= '0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  papu_mix_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_acc_clr),
    .i_en    (w_acc_en),
    .i_level (r_level),
    .i_gain  (w_gain_sel),
    .i_pub   (w_pub),
    .o_audio (w_audio)
  );

  assign o_ch_req       = r_ch_req;
  assign o_audio_output = w_audio;
  assign o_sample_valid = r_sample_valid;
  assign o_busy         = r_busy;
  assign o_overrun      = r_overrun;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_papu_mix_sequencer.sv
// tb_papu_mix_sequencer
// Self-checking bench for the APU mix sequencer. A responder process plays
// the channel side of the handshake with a per-channel ack delay; expected
// sample, latency, request order and flags come from a frame-level model.
module tb_papu_mix_sequencer;

   localparam int NUM_CH  = 4;
   localparam int TIMEOUT = 15;
   localparam int NEVER   = 255;

   logic                  clk = 1'b0;
   logic                  rstN = 1'b0;
   logic                  sampleReq = 1'b0;
   logic [NUM_CH-1:0]     chReq;
   logic [NUM_CH-1:0]     chAck = '0;
   logic [4*NUM_CH-1:0]   chLevel = '0;
   logic [4*NUM_CH-1:0]   gain = '0;
   logic [NUM_CH-1:0]     mute = '0;
   logic                  clrErr = 1'b0;
   logic [15:0]           audio;
   logic                  sampleValid;
   logic                  busy;
   logic                  overrun;
   logic                  timeoutErr;

   int  delay   [NUM_CH];
   int  levelV  [NUM_CH];
   int  gainV   [NUM_CH];
   bit  muteV   [NUM_CH];
   int  reqCnt  [NUM_CH];
   int  reqHigh [NUM_CH];
   int  order   [$];
   logic [NUM_CH-1:0] prevReq = '0;

   int  checkCount = 0;
   int  errorCount = 0;
   bit  expOvr = 1'b0;
   bit  expTmo = 1'b0;
   int  waitN;

   papu_mix_sequencer #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst_n          (rstN),
      .i_sample_req   (sampleReq),
      .o_ch_req       (chReq),
      .i_ch_ack       (chAck),
      .i_ch_level     (chLevel),
      .i_gain         (gain),
      .i_mute         (mute),
      .i_clr_err      (clrErr),
      .o_audio_output (audio),
      .o_sample_valid (sampleValid),
      .o_busy         (busy),
      .o_overrun      (overrun),
      .o_timeout_err  (timeoutErr)
   );

   always #5 clk = ~clk;

   // Channel side of the handshake: a requested channel acks after delay[i]
   // cycles with its real level; everything else sees random acks and levels
   // that the sequencer must ignore.
   always @(negedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (chReq[i]) begin
            if (!prevReq[i]) order.push_back(i);
            reqHigh[i]++;
            chAck[i] = (reqCnt[i] == delay[i]);
            chLevel[i*4 +: 4] = chAck[i] ? 4'(levelV[i]) : 4'($urandom);
            reqCnt[i]++;
         end else begin
            reqCnt[i] = 0;
            chAck[i] = 1'($urandom);
            chLevel[i*4 +: 4] = 4'($urandom);
         end
      end
      prevReq = chReq;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Pulse clr_err for one cycle and confirm both sticky flags drop.
   task automatic clearErrors();
      @(negedge clk);
      clrErr = 1'b1;
      @(negedge clk);
      clrErr = 1'b0;
      expOvr = 1'b0;
      expTmo = 1'b0;
      checkOutput("clrOverrun", overrun, 0);
      checkOutput("clrTimeout", timeoutErr, 0);
   endtask

   // Run one frame with the current channel setup. injectAt > 0 drops an
   // extra sample_req on that cycle of the frame (-1 picks one at random);
   // injectClr also pulses clr_err on that cycle when no timeout is planned.
   task automatic applyStimulus(input int injectAt, input bit injectClr);
      int expSum, expLat, n, w, inj;
      bit anyTmo, got, doClr;
      int expOrder[$];
      int expHigh[NUM_CH];
      logic [15:0] expAudio, prevAudio;

      expSum = 0;
      expLat = 2;
      anyTmo = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         expHigh[i] = 0;
         if (muteV[i]) begin
            expLat += 1;
         end else begin
            expOrder.push_back(i);
            if (delay[i] < TIMEOUT) begin
               w = delay[i] + 1;
               expSum += levelV[i] * gainV[i];
            end else begin
               w = TIMEOUT;
               anyTmo = 1'b1;
            end
            expHigh[i] = w;
            expLat += w + 2;
         end
      end
      expAudio = 16'(expSum * 32 - 14400);
      inj = (injectAt < 0) ? $urandom_range(1, expLat - 1) : injectAt;
      doClr = injectClr && !anyTmo && (inj > 0);
      if (anyTmo) expTmo = 1'b1;
      if (doClr) expTmo = 1'b0;
      if (inj > 0) expOvr = 1'b1;

      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
         gain[i*4 +: 4] = 4'(gainV[i]);
         mute[i] = muteV[i];
         reqHigh[i] = 0;
      end
      order.delete();
      prevAudio = audio;
      sampleReq = 1'b1;

      n = 0;
      got = 1'b0;
      while (!got && n < 300) begin
         @(negedge clk);
         n++;
         sampleReq = 1'b0;
         clrErr = 1'b0;
         if (sampleValid) begin
            got = 1'b1;
         end else begin
            checkOutput("busyInFrame", busy, 1);
            checkOutput("reqOnehot", $onehot0(chReq), 1);
            checkOutput("audioHeld", audio, prevAudio);
            if (n == inj) begin
               sampleReq = 1'b1;
               clrErr = doClr;
            end
         end
      end

      checkOutput("latency", n, expLat);
      checkOutput("audio", audio, expAudio);
      checkOutput("busyAtValid", busy, 0);
      checkOutput("overrun", overrun, expOvr);
      checkOutput("timeoutErr", timeoutErr, expTmo);
      checkOutput("reqCount", order.size(), expOrder.size());
      for (int k = 0; k < expOrder.size() && k < order.size(); k++)
         checkOutput("reqOrder", order[k], expOrder[k]);
      for (int i = 0; i < NUM_CH; i++)
         checkOutput("reqCycles", reqHigh[i], expHigh[i]);

      @(negedge clk);
      checkOutput("validWidth", sampleValid, 0);
      checkOutput("audioAfter", audio, expAudio);
      repeat (3) @(negedge clk);
      checkOutput("noSecondFrame", busy, 0);
   endtask

   task automatic setAll(input int lvl, input int gn, input int dly, input bit mt);
      for (int i = 0; i < NUM_CH; i++) begin
         levelV[i] = lvl;
         gainV[i]  = gn;
         delay[i]  = dly;
         muteV[i]  = mt;
      end
   endtask

   initial begin
      setAll(0, 0, 0, 1'b0);
      for (int i = 0; i < NUM_CH; i++) begin
         reqCnt[i] = 0;
         reqHigh[i] = 0;
      end

      // Reset held with random inputs: everything must stay at zero.
      repeat (6) begin
         @(negedge clk);
         sampleReq = 1'($urandom);
         clrErr    = 1'($urandom);
         gain      = 16'($urandom);
         mute      = 4'($urandom);
      end
      checkOutput("rstAudio", audio, 0);
      checkOutput("rstValid", sampleValid, 0);
      checkOutput("rstReq", chReq, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstOverrun", overrun, 0);
      checkOutput("rstTimeout", timeoutErr, 0);
      @(negedge clk);
      rstN = 1'b1;
      sampleReq = 1'b0;
      clrErr = 1'b0;
      repeat (5) begin
         @(negedge clk);
         checkOutput("idleBusy", busy, 0);
         checkOutput("idleReq", chReq, 0);
      end

      $display("[TB] full scale");
      setAll(15, 15, 0, 1'b0);
      applyStimulus(0, 1'b0);
      checkOutput("fullScale", audio, 16'h3840);

      $display("[TB] all muted");
      setAll(15, 15, 0, 1'b1);
      applyStimulus(0, 1'b0);
      checkOutput("allMuted", audio, 16'hC7C0);

      $display("[TB] channel 2 timeout");
      setAll(15, 15, 0, 1'b0);
      delay[2] = NEVER;
      applyStimulus(0, 1'b0);
      checkOutput("timeoutAudio", audio, 16'h1C20);
      checkOutput("timeoutFlag", timeoutErr, 1);
      clearErrors();

      $display("[TB] overrun during frame");
      setAll(15, 15, 0, 1'b0);
      applyStimulus(5, 1'b0);
      checkOutput("overrunAudio", audio, 16'h3840);
      checkOutput("overrunFlag", overrun, 1);
      clearErrors();

      $display("[TB] reset mid-frame");
      setAll(15, 15, 0, 1'b0);
      delay[1] = NEVER;
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
         gain[i*4 +: 4] = 4'(gainV[i]);
         mute[i] = muteV[i];
      end
      sampleReq = 1'b1;
      @(negedge clk);
      sampleReq = 1'b0;
      waitN = 0;
      while (chReq != 4'b0010 && waitN < 50) begin
         @(negedge clk);
         waitN++;
      end
      checkOutput("reachCh1Wait", chReq, 4'b0010);
      #2 rstN = 1'b0;
      #1;
      checkOutput("asyncReqDrop", chReq, 0);
      checkOutput("asyncBusyDrop", busy, 0);
      checkOutput("asyncNoValid", sampleValid, 0);
      @(negedge clk);
      checkOutput("rstNoValid", sampleValid, 0);
      rstN = 1'b1;
      expOvr = 1'b0;
      expTmo = 1'b0;
      delay[1] = 0;
      applyStimulus(0, 1'b0);
      checkOutput("afterRstAudio", audio, 16'h3840);

      $display("[TB] randomized frames");
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            int r;
            muteV[i]  = ($urandom_range(0, 3) == 0);
            levelV[i] = $urandom_range(0, 15);
            gainV[i]  = $urandom_range(0, 15);
            r = $urandom_range(0, 9);
            if (r < 5)       delay[i] = 0;
            else if (r < 8)  delay[i] = $urandom_range(0, 14);
            else if (r == 8) delay[i] = NEVER;
            else             delay[i] = $urandom_range(13, 20);
         end
         applyStimulus(($urandom_range(0, 2) == 0) ? -1 : 0, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) clearErrors();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
